// File: rtl/mult_seq.sv
// mult_seq -- sequential WIDTH x WIDTH multiplier, signed or unsigned per operation.
//
// Operand a is consumed DIGIT bits per clock against the full b, so an
// operation takes N = WIDTH/DIGIT compute cycles plus one finish cycle.
// Operands, sign mode and (optionally) accumulate mode are captured on the
// start edge; the inputs may change freely afterwards.
//
// Ports:
//   clk          clock, rising edge active
//   reset        asynchronous active-high reset
//   start        operation request, honoured only in IDLE
//   signed_mode  1 = two's complement operands, 0 = unsigned
//   acc_mode     (MULT_SEQ_ACC_EN only) 1 = add result to current product
//   a, b         operands, WIDTH bits each
//   busy         operation in progress (CALC or FINISH)
//   done         one-cycle strobe, product updated in the same cycle
//   product      registered 2*WIDTH result, holds until next completion
//
// Build option:
//   MULT_SEQ_ACC_EN  adds the acc_mode port and multiply-accumulate behaviour.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | waiting for start; done cleared here
// S_CALC   | one DIGIT-wide slice of |a| times |b| added per cycle
// S_FINISH | sign applied, product written, done strobed

module mult_seq #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   signed_mode,
`ifdef MULT_SEQ_ACC_EN
  input  logic                   acc_mode,
`endif
  input  logic [WIDTH-1:0]       a,
  input  logic [WIDTH-1:0]       b,
  output logic                   busy,
  output logic                   done,
  output logic [2*WIDTH-1:0]     product
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(N - 1);

  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("mult_seq: WIDTH must be >= 2");
    end
    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_digit
      $error("mult_seq: WIDTH must be a multiple of DIGIT");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_CALC   = 2'd1,
    S_FINISH = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     a_sh;     // |a|, shifted right one slice per CALC cycle
  logic [2*WIDTH-1:0]   b_sh;     // |b|, shifted left to the weight of the current slice
  logic [2*WIDTH-1:0]   acc;
  logic [CNT_W-1:0]     cnt;
  logic                 neg;
`ifdef MULT_SEQ_ACC_EN
  logic                 acc_q;
`endif

  logic [WIDTH-1:0]     a_mag;
  logic [WIDTH-1:0]     b_mag;
  logic [2*WIDTH-1:0]   partial;
  logic [2*WIDTH-1:0]   result;
  logic [2*WIDTH-1:0]   next_product;

  // The magnitude of the most negative value is 2^(WIDTH-1), which still fits
  // in WIDTH unsigned bits, so plain negation covers every case.
  always_comb begin
    a_mag = (signed_mode && a[WIDTH-1]) ? -a : a;
    b_mag = (signed_mode && b[WIDTH-1]) ? -b : b;
  end

  // b_sh already carries the slice weight, so no variable shifter is needed.
  // The product cannot exceed 2*WIDTH bits since slice weight + DIGIT <= WIDTH.
  always_comb begin
    partial = b_sh * {{(2*WIDTH-DIGIT){1'b0}}, a_sh[DIGIT-1:0]};
    result  = neg ? -acc : acc;
`ifdef MULT_SEQ_ACC_EN
    next_product = acc_q ? (product + result) : result;
`else
    next_product = result;
`endif
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      busy    <= 1'b0;
      done    <= 1'b0;
      product <= '0;
      a_sh    <= '0;
      b_sh    <= '0;
      acc     <= '0;
      cnt     <= '0;
      neg     <= 1'b0;
`ifdef MULT_SEQ_ACC_EN
      acc_q   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            a_sh  <= a_mag;
            b_sh  <= {{WIDTH{1'b0}}, b_mag};
            neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
            acc   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
`ifdef MULT_SEQ_ACC_EN
            acc_q <= acc_mode;
`endif
            state <= S_CALC;
          end
        end

        S_CALC: begin
          acc  <= acc + partial;
          a_sh <= a_sh >> DIGIT;
          b_sh <= b_sh << DIGIT;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_LAST) begin
            state <= S_FINISH;
          end
        end

        S_FINISH: begin
          product <= next_product;
          done    <= 1'b1;
          busy    <= 1'b0;
          state   <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

endmodule
